// File: rtl/uart_tx_buffered.sv
// UART transmitter: 1 start bit, NB_DATA data bits LSB first, 1 stop bit, no parity.
// Paced by a shared 16x baud tick. A one-entry holding buffer captures a request
// strobed during an active frame and sends it back-to-back after the current stop bit.
module uart_tx_buffered #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned NB_TICK = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy,
  output logic               o_full
);

  localparam int unsigned NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TICK-1:0] TICK_LAST = {NB_TICK{1'b1}};
  localparam logic [NB_TICK-1:0] STOP_LAST = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [NB_TICK-1:0]   tick_q, tick_d;
  logic [NB_BIT-1:0]    bit_q, bit_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic [NB_DATA-1:0]   hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 frame_end;

  // Final tick of the stop bit; the buffer is consumed here, so it must not also capture.
  assign frame_end = (state_q == StStop) && i_tick && (tick_q == STOP_LAST);

  // Next-state, bit timing, buffer handling and registered line level.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_tx_start) begin
          shift_d = i_data;
          tick_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            done_d = 1'b1;
            tick_d = '0;
            if (full_q) begin
              shift_d = hold_q;
              full_d  = 1'b0;
              state_d = StStart;
            end else if (i_tx_start) begin
              shift_d = i_data;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Requests arriving mid-frame park in the buffer; a second one is dropped.
    if ((state_q != StIdle) && i_tx_start && !full_q && !frame_end) begin
      hold_d = i_data;
      full_d = 1'b1;
    end

    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and empties the buffer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = (state_q != StIdle);
  assign o_full    = full_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame timing, buffering, drop, reset abort,
// and a request coincident with the final stop tick.
module tb_uart_tx_buffered;

  logic       i_clk;
  logic       i_reset;
  logic       i_tick;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_busy;
  logic       o_full;

  int checks   = 0;
  int failures = 0;
  int tick_period = 1;
  int phase = 0;

  uart_tx_buffered #(
    .NB_DATA (8),
    .SB_TICK (16),
    .NB_TICK (4)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy),
    .o_full     (o_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; i_tick fires when phase is 0. Returns 1 time unit after the edge.
  task automatic cycle();
    i_tick = (phase == 0);
    @(posedge i_clk);
    #1;
    phase = (phase + 1) % tick_period;
  endtask

  function automatic logic exp_level(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Called 1 unit after the edge that accepted the request for data.
  task automatic check_frame(input logic [7:0] d, input int inj1_at, input logic [7:0] inj1_d,
                             input int inj2_at, input logic [7:0] inj2_d, input logic next_pending);
    int len;
    len = 16 * tick_period;
    for (int n = 0; n < 10 * len; n++) begin
      int b;
      int k;
      b = n / len;
      k = n % len;
      if (k == 0 || k == len / 2 || k == len - 1)
        check($sformatf("tx d=%0h bit%0d k%0d", d, b, k), {7'd0, o_tx}, {7'd0, exp_level(d, b)});
      if (k == len / 2) begin
        check($sformatf("full d=%0h bit%0d", d, b), {7'd0, o_full},
              {7'd0, (inj1_at >= 0) && (n > inj1_at)});
        check($sformatf("busy d=%0h bit%0d", d, b), {7'd0, o_busy}, 8'd1);
      end
      if (k == len - 1)
        check($sformatf("done early d=%0h bit%0d", d, b), {7'd0, o_tx_done}, 8'd0);
      if (n == inj1_at) begin
        i_tx_start = 1'b1;
        i_data = inj1_d;
      end
      if (n == inj2_at) begin
        i_tx_start = 1'b1;
        i_data = inj2_d;
      end
      cycle();
      i_tx_start = 1'b0;
    end
    check($sformatf("done d=%0h", d), {7'd0, o_tx_done}, 8'd1);
    check($sformatf("tx after d=%0h", d), {7'd0, o_tx}, {7'd0, !next_pending});
    check($sformatf("busy after d=%0h", d), {7'd0, o_busy}, {7'd0, next_pending});
    check($sformatf("full after d=%0h", d), {7'd0, o_full}, 8'd0);
    if (!next_pending) begin
      cycle();
      check($sformatf("done pulse d=%0h", d), {7'd0, o_tx_done}, 8'd0);
      check($sformatf("idle busy d=%0h", d), {7'd0, o_busy}, 8'd0);
      check($sformatf("idle tx d=%0h", d), {7'd0, o_tx}, 8'd1);
    end
  endtask

  task automatic send(input logic [7:0] d);
    phase = 0;
    i_tx_start = 1'b1;
    i_data = d;
    cycle();
    i_tx_start = 1'b0;
  endtask

  initial begin
    logic done_seen;
    i_reset = 1'b0;
    i_tick = 1'b0;
    i_tx_start = 1'b0;
    i_data = 8'h00;
    #2 i_reset = 1'b1;
    #1;
    check("reset tx", {7'd0, o_tx}, 8'd1);
    check("reset done", {7'd0, o_tx_done}, 8'd0);
    check("reset busy", {7'd0, o_busy}, 8'd0);
    check("reset full", {7'd0, o_full}, 8'd0);
    for (int i = 0; i < 3; i++) cycle();
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("idle with ticks tx", {7'd0, o_tx}, 8'd1);
    check("idle with ticks busy", {7'd0, o_busy}, 8'd0);

    // 0x55, tick every cycle.
    tick_period = 1;
    send(8'h55);
    check_frame(8'h55, -1, 8'h00, -1, 8'h00, 1'b0);

    // 0x0F, tick every 4th cycle.
    tick_period = 4;
    send(8'h0F);
    check_frame(8'h0F, -1, 8'h00, -1, 8'h00, 1'b0);

    // 0xA3 then 0x3C buffered and sent back-to-back.
    tick_period = 1;
    send(8'hA3);
    check_frame(8'hA3, 70, 8'h3C, -1, 8'h00, 1'b1);
    check_frame(8'h3C, -1, 8'h00, -1, 8'h00, 1'b0);

    // 0x11, then 0x22 buffered and 0x33 dropped.
    send(8'h11);
    check_frame(8'h11, 40, 8'h22, 90, 8'h33, 1'b1);
    check_frame(8'h22, -1, 8'h00, -1, 8'h00, 1'b0);

    // Reset during data bit 3 of 0x81 with the buffer also occupied.
    send(8'h81);
    i_tx_start = 1'b1;
    i_data = 8'h5A;
    cycle();
    i_tx_start = 1'b0;
    for (int i = 0; i < 69; i++) cycle();
    check("pre-reset tx bit3", {7'd0, o_tx}, 8'd0);
    check("pre-reset full", {7'd0, o_full}, 8'd1);
    i_reset = 1'b1;
    #1;
    check("abort tx", {7'd0, o_tx}, 8'd1);
    check("abort busy", {7'd0, o_busy}, 8'd0);
    check("abort full", {7'd0, o_full}, 8'd0);
    check("abort done", {7'd0, o_tx_done}, 8'd0);
    for (int i = 0; i < 3; i++) cycle();
    i_reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (o_tx_done || !o_tx || o_busy) done_seen = 1'b1;
    end
    check("post-reset quiet", {7'd0, done_seen}, 8'd0);
    send(8'h81);
    check_frame(8'h81, -1, 8'h00, -1, 8'h00, 1'b0);

    // 0x7E requested on the final stop tick of 0x01 with the buffer empty.
    send(8'h01);
    check_frame(8'h01, 159, 8'h7E, -1, 8'h00, 1'b1);
    check_frame(8'h7E, -1, 8'h00, -1, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
